// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner and its on-chip keypad emulator:
// emulator state encoding, row-select patterns, digit-to-scan-code map and the
// bounce LFSR step function.
package keypad_pkg;

   // Emulator state encoding
   localparam logic [2:0] STATE_IDLE       = 3'd0;
   localparam logic [2:0] STATE_BOUNCE_IN  = 3'd1;
   localparam logic [2:0] STATE_HOLD       = 3'd2;
   localparam logic [2:0] STATE_BOUNCE_OUT = 3'd3;
   localparam logic [2:0] STATE_GAP        = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE       = STATE_IDLE,
      ST_BOUNCE_IN  = STATE_BOUNCE_IN,
      ST_HOLD       = STATE_HOLD,
      ST_BOUNCE_OUT = STATE_BOUNCE_OUT,
      ST_GAP        = STATE_GAP
   } state_t;

   // Active-low row-select patterns driven by the scanner
   localparam logic [3:0] ROW_SEL_0 = 4'b1110;
   localparam logic [3:0] ROW_SEL_1 = 4'b1101;
   localparam logic [3:0] ROW_SEL_2 = 4'b1011;
   localparam logic [3:0] ROW_SEL_3 = 4'b0111;

   // Scan code = {row index, column index}
   localparam logic [3:0] KEY_CLEAR = 4'h8;

   // Bounce generator reset value; any non-zero seed works
   localparam logic [7:0] LFSR_SEED = 8'hA5;

   // Map a decimal digit (0-9) to its scan code; anything else is the clear key
   function automatic logic [3:0] digit_to_code(input logic [3:0] digit);
      logic [3:0] code;
      case (digit)
         4'd0:    code = 4'hC;
         4'd1:    code = 4'hD;
         4'd2:    code = 4'h9;
         4'd3:    code = 4'h5;
         4'd4:    code = 4'hE;
         4'd5:    code = 4'hA;
         4'd6:    code = 4'h6;
         4'd7:    code = 4'hF;
         4'd8:    code = 4'hB;
         4'd9:    code = 4'h7;
         default: code = KEY_CLEAR;
      endcase
      return code;
   endfunction

   // One Fibonacci step of x^8+x^6+x^5+x^4+1 (maximal length, zero never reached
   // from a non-zero seed)
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

endpackage

// File: rtl/keypad_emulator_bounce_lfsr.sv
// Free-running 8-bit pseudo-random source used to make contact bounce.
module bounce_lfsr
   import keypad_pkg::*;
#(
   parameter logic [7:0] SEED = LFSR_SEED
) (
   input  logic       CLK,
   input  logic       RESET,
   output logic [7:0] lfsr_state
);

   logic [7:0] lfsr_d;
   logic [7:0] lfsr_q;

   // Next LFSR value; the register advances on every clock
   always_comb begin
      lfsr_d = lfsr_next(lfsr_q);
   end

   // LFSR register, reloads the seed on reset
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr_state = lfsr_q;

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad model: accepts one key request at a time and plays it back
// as bounce-in, solid hold, bounce-out and an open gap, answering the scanner's
// active-low ROW drive with an active-high COLUMN return.
//
// Handshake: KEY_REQ is sampled only while idle; the accepting edge latches
// KEY_CODE and BUSY rises right after it. Requests while BUSY are dropped, not
// queued. DONE is a single-cycle pulse in the first idle cycle after the gap,
// and a request presented in that cycle is accepted.
module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int BOUNCE_CYCLES = 2000,
   parameter int HOLD_CYCLES   = 200000,
   parameter int GAP_CYCLES    = 50000,
   parameter int CNT_W         = 24
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       KEY_REQ,
   input  logic [3:0] KEY_CODE,
   input  logic [3:0] ROW,
   output logic [3:0] COLUMN,
   output logic       BUSY,
   output logic       DONE
);

   // Terminal counts; the bounce value is unused when bounce is disabled
   localparam bit             HAS_BOUNCE  = (BOUNCE_CYCLES != 0);
   localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

   state_t           state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [1:0]       r_row_q,   r_row_d;
   logic [1:0]       r_col_q,   r_col_d;
   logic             contact_q, contact_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;

   logic [7:0]       lfsr_state;
   logic             unused_lfsr;

   bounce_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .CLK        (CLK),
      .RESET      (RESET),
      .lfsr_state (lfsr_state)
   );

   // Only bit 0 drives bounce; the rest of the state is carried for observability
   assign unused_lfsr = ^lfsr_state[7:1];

   // Phase sequencing: each phase runs until its counter reaches PARAM-1
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      r_row_d = r_row_q;
      r_col_d = r_col_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (KEY_REQ) begin
               r_row_d = KEY_CODE[3:2];
               r_col_d = KEY_CODE[1:0];
               state_d = HAS_BOUNCE ? ST_BOUNCE_IN : ST_HOLD;
            end
         end
         ST_BOUNCE_IN: begin
            if (cnt_q == BOUNCE_LAST) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = HAS_BOUNCE ? ST_BOUNCE_OUT : ST_GAP;
               cnt_d   = '0;
            end
         end
         ST_BOUNCE_OUT: begin
            if (cnt_q == BOUNCE_LAST) begin
               state_d = ST_GAP;
               cnt_d   = '0;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Registered outputs computed from the state being entered, so contact,
   // BUSY and DONE line up with the cycle they describe
   always_comb begin
      contact_d = 1'b0;
      case (state_d)
         ST_HOLD:       contact_d = 1'b1;
         // Last bounce-in cycle lands closed so HOLD starts from a clean make
         ST_BOUNCE_IN:  contact_d = (cnt_d == BOUNCE_LAST) ? 1'b1 : lfsr_state[0];
         // Last bounce-out cycle lands open so GAP starts from a clean break
         ST_BOUNCE_OUT: contact_d = (cnt_d == BOUNCE_LAST) ? 1'b0 : lfsr_state[0];
         default:       contact_d = 1'b0;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_q == ST_GAP) && (state_d == ST_IDLE);
   end

   // FSM, phase counter, latched key and output registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         r_row_q   <= 2'd0;
         r_col_q   <= 2'd0;
         contact_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         r_row_q   <= r_row_d;
         r_col_q   <= r_col_d;
         contact_q <= contact_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Column return follows ROW with no register stage; other rows are don't-care
   always_comb begin
      COLUMN = 4'h0;
      if (contact_q && !ROW[r_row_q]) begin
         COLUMN[r_col_q] = 1'b1;
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: two builds (bounce 8 and bounce 0) share one
// stimulus stream and are both checked every cycle against a phase-offset model.
module tb_keypad_emulator;

   localparam int H = 40;
   localparam int G = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_req;
   logic [3:0] key_code;
   logic [3:0] row;
   logic [3:0] col_o  [2];
   logic       busy_o [2];
   logic       done_o [2];

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Model: per build, whether a press is live and its offset since acceptance
   int         bcyc      [2] = '{8, 0};
   bit         m_active  [2];
   int         m_t       [2];
   logic [3:0] m_code    [2];
   int         done_cnt  [2];
   int         last_done [2];

   logic [3:0] digit_code [10] = '{4'hC, 4'hD, 4'h9, 4'h5, 4'hE,
                                   4'hA, 4'h6, 4'hF, 4'hB, 4'h7};

   typedef struct {
      logic [3:0] row;
      logic [3:0] exp_col;
      logic       exp_busy;
   } vec_t;

   always #5 clk = ~clk;

   keypad_emulator #(
      .BOUNCE_CYCLES (8), .HOLD_CYCLES (H), .GAP_CYCLES (G), .CNT_W (24)
   ) dut_a (
      .CLK (clk), .RESET (rst), .KEY_REQ (key_req), .KEY_CODE (key_code),
      .ROW (row), .COLUMN (col_o[0]), .BUSY (busy_o[0]), .DONE (done_o[0])
   );

   keypad_emulator #(
      .BOUNCE_CYCLES (0), .HOLD_CYCLES (H), .GAP_CYCLES (G), .CNT_W (24)
   ) dut_b (
      .CLK (clk), .RESET (rst), .KEY_REQ (key_req), .KEY_CODE (key_code),
      .ROW (row), .COLUMN (col_o[1]), .BUSY (busy_o[1]), .DONE (done_o[1])
   );

   function automatic int total_of(input int d);
      return 2 * bcyc[d] + H + G;
   endfunction

   // 0 = open, 1 = closed, 2 = bouncing (either)
   function automatic int contact_class(input int d);
      int t;
      int b;
      t = m_t[d];
      b = bcyc[d];
      if (!m_active[d] || t >= total_of(d)) return 0;
      if (t < b) return (t == b - 1) ? 1 : 2;
      if (t < b + H) return 1;
      if (t < 2 * b + H) return (t == 2 * b + H - 1) ? 0 : 2;
      return 0;
   endfunction

   task automatic check(input string name, input bit ok, input int act, input int exp);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) m_active[d] = 1'b0;
   endtask

   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_active[d] = 1'b0;
         end else if ((!m_active[d] || m_t[d] >= total_of(d)) && key_req) begin
            m_active[d] = 1'b1;
            m_t[d]      = 0;
            m_code[d]   = key_code;
         end else if (m_active[d]) begin
            m_t[d]++;
         end
      end
   endtask

   task automatic check_outputs();
      logic [3:0] e;
      bit         eb;
      bit         ed;
      int         cls;
      bit         ok;
      string      sfx;
      for (int d = 0; d < 2; d++) begin
         sfx = (d == 0) ? "a" : "b";
         eb  = m_active[d] && (m_t[d] <  total_of(d));
         ed  = m_active[d] && (m_t[d] == total_of(d));
         cls = contact_class(d);
         e   = 4'h0;
         if (row[m_code[d][3:2]] == 1'b0) e[m_code[d][1:0]] = 1'b1;
         if (cls == 0) begin
            ok = (col_o[d] == 4'h0);
            e  = 4'h0;
         end else if (cls == 1) begin
            ok = (col_o[d] == e);
         end else begin
            ok = (col_o[d] == 4'h0) || (col_o[d] == e);
         end
         check({"busy_", sfx}, busy_o[d] == eb, int'(busy_o[d]), int'(eb));
         check({"done_", sfx}, done_o[d] == ed, int'(done_o[d]), int'(ed));
         check({"column_", sfx}, ok, int'(col_o[d]), int'(e));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      check_outputs();
      for (int d = 0; d < 2; d++) begin
         if (done_o[d]) begin
            done_cnt[d]++;
            last_done[d] = cyc;
         end
      end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((busy_o[0] || busy_o[1]) && n < budget) begin
         tick();
         n++;
      end
      check("idle_timeout", !(busy_o[0] || busy_o[1]), int'(busy_o[0]), 0);
   endtask

   task automatic press(input logic [3:0] code);
      key_code = code;
      key_req  = 1'b1;
      tick();
      key_req  = 1'b0;
   endtask

   initial begin
      vec_t       vecs [12];
      logic [3:0] rot  [5];
      int         c0;
      int         n;
      int         t;
      int         idx;
      int         hits;
      int         row7;
      int         dc;
      bit         saw_open;
      bit         saw_closed;
      int         answer;
      logic [1:0] ri;
      logic [1:0] ci;

      vecs = '{'{4'b1110, 4'b0000, 1'b1}, '{4'b1101, 4'b0000, 1'b1},
               '{4'b1011, 4'b0000, 1'b1}, '{4'b0111, 4'b0010, 1'b1},
               '{4'b1111, 4'b0000, 1'b1}, '{4'b0011, 4'b0010, 1'b1},
               '{4'b0110, 4'b0010, 1'b1}, '{4'b0000, 4'b0010, 1'b1},
               '{4'b1000, 4'b0000, 1'b1}, '{4'b0101, 4'b0010, 1'b1},
               '{4'b1010, 4'b0000, 1'b1}, '{4'b0111, 4'b0010, 1'b1}};
      rot = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hF};

      rst      = 1'b0;
      key_req  = 1'b0;
      key_code = 4'h0;
      row      = 4'hF;
      model_reset();
      for (int d = 0; d < 2; d++) begin
         done_cnt[d]  = 0;
         last_done[d] = -1;
      end

      // 1: reset asserted mid-clock takes effect immediately and holds
      #3 rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         check("reset_column", col_o[d] == 4'h0, int'(col_o[d]), 0);
         check("reset_busy", busy_o[d] == 1'b0, int'(busy_o[d]), 0);
         check("reset_done", done_o[d] == 1'b0, int'(done_o[d]), 0);
      end
      key_code = 4'hD;
      key_req  = 1'b1;
      row      = 4'h7;
      repeat (3) tick();
      key_req = 1'b0;
      rst     = 1'b0;
      repeat (2) tick();

      // 2: digit 1 with row 3 held low; latency and bounce activity
      row        = 4'b0111;
      c0         = cyc;
      hits       = 0;
      saw_open   = 1'b0;
      saw_closed = 1'b0;
      n          = 0;
      key_code   = 4'hD;
      key_req    = 1'b1;
      do begin
         tick();
         key_req = 1'b0;
         n++;
         t = m_t[0];
         if ((t >= 0 && t < 7) || (t >= 48 && t < 55)) begin
            if (col_o[0] == 4'h0) saw_open = 1'b1;
            else saw_closed = 1'b1;
         end
         if (t >= 8 && t < 48 && col_o[0] == 4'b0010) hits++;
      end while (!done_o[0] && n < 200);
      check("done_latency_a", done_o[0] && (cyc - c0 == 67), cyc - c0, 67);
      check("done_latency_b", last_done[1] - c0 == 51, last_done[1] - c0, 51);
      check("hold_column_cycles", hits == H, hits, H);
      check("bounce_toggles", saw_open && saw_closed, {saw_open, saw_closed}, 3);

      // 3: scanner rotating rows, then a table of row patterns during HOLD
      idx  = 0;
      hits = 0;
      row7 = 0;
      n    = 0;
      press(4'hD);
      while (m_active[0] && m_t[0] < total_of(0) && n < 200) begin
         row = rot[idx];
         idx = (idx + 1) % 5;
         tick();
         n++;
         if (m_t[0] >= 8 && m_t[0] < 48) begin
            if (row == 4'b0111) row7++;
            if (col_o[0] != 4'h0) hits++;
         end
      end
      check("rot_hold_hits", hits == row7 && row7 > 0, hits, row7);
      wait_idle(100);

      row = 4'b0111;
      press(4'hD);
      n = 0;
      while (m_t[0] < 10 && n < 50) begin
         tick();
         n++;
      end
      foreach (vecs[i]) begin
         row = vecs[i].row;
         #1;
         check("vec_column", col_o[0] == vecs[i].exp_col, int'(col_o[0]), int'(vecs[i].exp_col));
         check("vec_busy", busy_o[0] == vecs[i].exp_busy, int'(busy_o[0]), int'(vecs[i].exp_busy));
         tick();
      end
      row = 4'b0111;
      wait_idle(100);

      // 4: request during HOLD is dropped; request on the DONE cycle is taken
      dc = done_cnt[0];
      press(4'hD);
      n = 0;
      while (m_t[0] < 20 && n < 50) begin
         tick();
         n++;
      end
      press(4'h5);
      n = 0;
      while (m_t[0] < 30 && n < 50) begin
         tick();
         n++;
      end
      check("ignored_req_column", col_o[0] == 4'b0010, int'(col_o[0]), 2);
      n = 0;
      while (!done_o[0] && n < 200) begin
         tick();
         n++;
      end
      check("single_done", done_cnt[0] - dc == 1, done_cnt[0] - dc, 1);
      press(4'hE);
      check("done_cycle_accept", busy_o[0] == 1'b1, int'(busy_o[0]), 1);
      repeat (20) tick();
      check("third_key_column", col_o[0] == 4'b0100, int'(col_o[0]), 4);
      wait_idle(100);
      repeat (2) tick();

      // 5: reset during HOLD of key 7
      row = 4'b1101;
      press(4'h7);
      n = 0;
      while (m_t[0] < 20 && n < 50) begin
         tick();
         n++;
      end
      check("pre_reset_column", col_o[0] == 4'b1000, int'(col_o[0]), 8);
      dc = done_cnt[0] + done_cnt[1];
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("midreset_column_a", col_o[0] == 4'h0, int'(col_o[0]), 0);
      check("midreset_busy_a", busy_o[0] == 1'b0, int'(busy_o[0]), 0);
      check("midreset_column_b", col_o[1] == 4'h0, int'(col_o[1]), 0);
      repeat (3) tick();
      rst = 1'b0;
      repeat (80) tick();
      check("no_done_after_reset", done_cnt[0] + done_cnt[1] == dc, done_cnt[0] + done_cnt[1] - dc, 0);

      // 6: no-bounce build, key 0 (4'hC)
      row = 4'b0111;
      c0  = cyc;
      press(4'hC);
      check("nb_busy", busy_o[1] == 1'b1, int'(busy_o[1]), 1);
      check("nb_column", col_o[1] == 4'b0001, int'(col_o[1]), 1);
      hits = 1;
      n    = 0;
      while (!done_o[1] && n < 200) begin
         tick();
         n++;
         if (m_t[1] < H && col_o[1] == 4'b0001) hits++;
      end
      check("nb_hold_cycles", hits == H, hits, H);
      check("nb_done_latency", cyc - c0 == 51, cyc - c0, 51);
      wait_idle(100);

      // Scanner in loop: rotate rows, decode the return, map back to a digit
      answer = 15;
      idx    = 0;
      press(4'hC);
      n = 0;
      while (busy_o[1] && n < 200) begin
         row = rot[idx];
         idx = (idx + 1) % 4;
         tick();
         n++;
         if (col_o[1] != 4'h0 && answer == 15) begin
            ri = 2'd0;
            ci = 2'd0;
            for (int r = 0; r < 4; r++) if (row[r] == 1'b0) ri = 2'(r);
            for (int c = 0; c < 4; c++) if (col_o[1][c]) ci = 2'(c);
            for (int k = 0; k < 10; k++) if (digit_code[k] == {ri, ci}) answer = k;
         end
      end
      check("scanner_digit", answer == 0, answer, 0);
      wait_idle(100);

      // Random traffic: random rows, sparse requests, random codes
      for (int i = 0; i < 1500; i++) begin
         row      = 4'($urandom_range(0, 15));
         key_code = 4'($urandom_range(0, 15));
         key_req  = ($urandom_range(0, 9) == 0);
         tick();
      end
      key_req = 1'b0;
      wait_idle(200);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
